// File: rtl/bs_rotate_arbiter.sv
// -----------------------------------------------------------------------------
// bs_rotate_arbiter
//
// Shares one combinational rotate-left/right barrel shifter between two
// requesters. A round-robin grant picks one request in IDLE, the operand,
// amount and direction are registered and driven to the shifter for one
// cycle (EXEC), the shifter result is captured and held on the winner's
// response channel until it is taken (RESP).
//
// Ports
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_reqN_valid/_A/_k/_left      request channel N (operand, amount, dir)
//   o_reqN_ready                  request N accepted when high with valid
//   o_rspN_valid/_Y               response channel N (rotated result)
//   i_rspN_ready                  requester N takes the result
//   o_bs_A/_k/_left               operand/amount/direction to the shifter
//   i_bs_Y                        shifter result, combinational from o_bs_*
//   o_busy                        high whenever a transaction is in flight
// -----------------------------------------------------------------------------
module bs_rotate_arbiter #(
    parameter int DWIDTH = 4,
    parameter int KWIDTH = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,

    input  logic              i_req0_valid,
    input  logic [DWIDTH-1:0] i_req0_A,
    input  logic [KWIDTH-1:0] i_req0_k,
    input  logic              i_req0_left,
    output logic              o_req0_ready,

    input  logic              i_req1_valid,
    input  logic [DWIDTH-1:0] i_req1_A,
    input  logic [KWIDTH-1:0] i_req1_k,
    input  logic              i_req1_left,
    output logic              o_req1_ready,

    output logic              o_rsp0_valid,
    output logic [DWIDTH-1:0] o_rsp0_Y,
    input  logic              i_rsp0_ready,

    output logic              o_rsp1_valid,
    output logic [DWIDTH-1:0] o_rsp1_Y,
    input  logic              i_rsp1_ready,

    output logic [DWIDTH-1:0] o_bs_A,
    output logic [KWIDTH-1:0] o_bs_k,
    output logic              o_bs_left,
    input  logic [DWIDTH-1:0] i_bs_Y,

    output logic              o_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              prio_q,  prio_d;   // requester that wins a tie
    logic              id_q,    id_d;     // requester owning the transaction
    logic [DWIDTH-1:0] a_q,     a_d;
    logic [KWIDTH-1:0] k_q,     k_d;
    logic              left_q,  left_d;
    logic [DWIDTH-1:0] y_q,     y_d;

    logic              grant_valid;
    logic              grant_id;
    logic              rsp_taken;

    // Round-robin grant: a lone request always wins, a tie goes to prio_q.
    always_comb begin
        grant_valid = i_req0_valid | i_req1_valid;
        if (i_req0_valid && i_req1_valid) begin
            grant_id = prio_q;
        end else begin
            grant_id = i_req1_valid;
        end
    end

    assign rsp_taken = id_q ? i_rsp1_ready : i_rsp0_ready;
    assign o_busy    = (state_q != IDLE);

    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d      = state_q;
        prio_d       = prio_q;
        id_d         = id_q;
        a_d          = a_q;
        k_d          = k_q;
        left_d       = left_q;
        y_d          = y_q;

        o_req0_ready = 1'b0;
        o_req1_ready = 1'b0;
        o_rsp0_valid = 1'b0;
        o_rsp1_valid = 1'b0;
        o_rsp0_Y     = '0;
        o_rsp1_Y     = '0;
        o_bs_A       = '0;
        o_bs_k       = '0;
        o_bs_left    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Ready is masked during reset so every output reads 0 then.
                if (grant_valid && !i_rst) begin
                    o_req0_ready = (grant_id == 1'b0);
                    o_req1_ready = (grant_id == 1'b1);
                    id_d         = grant_id;
                    a_d          = grant_id ? i_req1_A    : i_req0_A;
                    k_d          = grant_id ? i_req1_k    : i_req0_k;
                    left_d       = grant_id ? i_req1_left : i_req0_left;
                    state_d      = EXEC;
                end
            end

            EXEC: begin
                o_bs_A    = a_q;
                o_bs_k    = k_q;
                o_bs_left = left_q;
                y_d       = i_bs_Y;
                state_d   = RESP;
            end

            RESP: begin
                o_rsp0_valid = (id_q == 1'b0);
                o_rsp1_valid = (id_q == 1'b1);
                o_rsp0_Y     = (id_q == 1'b0) ? y_q : '0;
                o_rsp1_Y     = (id_q == 1'b1) ? y_q : '0;
                if (rsp_taken) begin
                    prio_d  = ~id_q;          // just-served requester goes last
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // NOTE: the operand/result registers are cleared on reset too,
            // since they must read back as zero after reset.
            state_q <= IDLE;
            prio_q  <= 1'b0;
            id_q    <= 1'b0;
            a_q     <= '0;
            k_q     <= '0;
            left_q  <= 1'b0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            id_q    <= id_d;
            a_q     <= a_d;
            k_q     <= k_d;
            left_q  <= left_d;
            y_q     <= y_d;
        end
    end

endmodule
